// File: rtl/mux_arbiter.sv
module mux_arbiter #(
  parameter int          NREQ     = 11,
  parameter logic [3:0]  IDLE_SEL = 4'b1111
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [3:0]      Sel,
  input  logic [17:0]     DatSal,
  output logic [17:0]     out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NREQ-1:0] grant,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, SELECT, HOLD} state_t;

  state_t     state;
  logic [3:0] last;
  logic [3:0] cur;
  logic [3:0] pick;
  logic [3:0] idx;
  logic       found;

  // Round-robin search: first set req bit starting at last+1, wrapping modulo NREQ.
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = 4'((32'(last) + k) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      Sel       <= IDLE_SEL;
      out_data  <= '0;
      out_valid <= 1'b0;
      grant     <= '0;
      busy      <= 1'b0;
      last      <= 4'(NREQ - 1);
      cur       <= '0;
    end else begin
      grant <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            Sel   <= pick;
            cur   <= pick;
            state <= SELECT;
            busy  <= 1'b1;
          end else begin
            Sel   <= IDLE_SEL;
            busy  <= 1'b0;
          end
        end
        SELECT: begin
          out_data  <= DatSal;
          out_valid <= 1'b1;
          state     <= HOLD;
          busy      <= 1'b1;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            grant[cur] <= 1'b1;
            last       <= cur;
            Sel        <= IDLE_SEL;
            state      <= IDLE;
            busy       <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          Sel   <= IDLE_SEL;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_arbiter.sv
module tb_mux_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] req;
  logic [3:0]  Sel;
  logic [17:0] DatSal;
  logic [17:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] grant;
  logic        busy;

  logic [17:0] dat [11];

  int checks   = 0;
  int failures = 0;
  int glog[$];

  always #5 clk = ~clk;

  // 16x1 mux model: unused codes give 0
  always_comb begin
    DatSal = '0;
    if (Sel < 4'd11) DatSal = dat[Sel];
  end

  mux_arbiter #(.NREQ(11), .IDLE_SEL(4'b1111)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .Sel(Sel), .DatSal(DatSal),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .grant(grant), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a transfer is the pair (chosen index, cycles elapsed).
  int          m_last;
  int          m_cur;
  int          m_age;      // 0 = no transfer, 1 = just chosen, 2 = word captured
  logic [3:0]  m_sel;
  logic [17:0] m_data;
  logic        m_valid;
  logic [10:0] m_grant;
  logic        m_busy;

  function automatic int rr_pick(input logic [10:0] r, input int lst);
    int best = -1;
    int bestd = 99;
    for (int i = 0; i < 11; i++) begin
      if (r[i]) begin
        int d = (i - lst - 1 + 22) % 11;  // distance after the rotation pointer
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_last = 10; m_cur = 0; m_age = 0;
      m_sel = 4'hF; m_data = '0; m_valid = 1'b0; m_grant = '0; m_busy = 1'b0;
    end else begin
      m_grant = '0;
      if (m_age == 0) begin
        if (req != 0) begin
          m_cur = rr_pick(req, m_last);
          m_sel = 4'(m_cur);
          m_age = 1;
        end else begin
          m_sel = 4'hF;
        end
      end else if (m_age == 1) begin
        m_data  = dat[m_cur];
        m_valid = 1'b1;
        m_age   = 2;
      end else if (out_ready) begin
        m_valid = 1'b0;
        m_grant = 11'(1) << m_cur;
        m_last  = m_cur;
        m_sel   = 4'hF;
        m_age   = 0;
      end
      m_busy = (m_age != 0);
    end
  end

  always @(negedge clk) begin
    chk("sel", 32'(Sel), 32'(m_sel));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("grant", 32'(grant), 32'(m_grant));
    chk("busy", 32'(busy), 32'(m_busy));
    if (m_valid) chk("out_data", 32'(out_data), 32'(m_data));
    chk("sel_range", 32'(Sel >= 4'd11 && Sel <= 4'd14), 32'(0));
    chk("grant_onehot", 32'($countones(grant) <= 1), 32'(1));
    for (int i = 0; i < 11; i++) if (grant[i]) glog.push_back(i);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic wait_grants(input int n, input int bound);
    int target = glog.size() + n;
    for (int c = 0; c < bound; c++) begin
      if (glog.size() >= target) break;
      tick();
    end
    chk("wait_grant", 32'(glog.size()), 32'(target));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; req = '0; out_ready = 1'b0;
    for (int i = 0; i < 11; i++) dat[i] = 18'(32'h1000 * (i + 1) + i);
    do_reset();

    // reset state
    chk("rst_sel", 32'(Sel), 32'hF);
    chk("rst_valid", 32'(out_valid), 32'(0));
    chk("rst_data", 32'(out_data), 32'(0));
    chk("rst_grant", 32'(grant), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));

    // single transfer, consumer always ready
    dat[0] = 18'h2A5A5; req = 11'h001; out_ready = 1'b1;
    tick(); chk("t1_sel", 32'(Sel), 32'(0)); chk("t1_busy", 32'(busy), 32'(1));
    tick(); chk("t1_data", 32'(out_data), 32'h2A5A5); chk("t1_valid", 32'(out_valid), 32'(1));
    tick(); chk("t1_grant", 32'(grant), 32'h001); chk("t1_sel_idle", 32'(Sel), 32'hF);
    req = '0;
    tick(); chk("t1_grant_clr", 32'(grant), 32'(0));

    // all requesting: full rotation then wrap
    do_reset();
    glog.delete();
    req = 11'h7FF;
    wait_grants(12, 60);
    req = '0;
    repeat (2) tick();
    chk("rr_count", 32'(glog.size()), 32'(12));
    for (int i = 0; i < 12 && i < glog.size(); i++) chk("rr_order", 32'(glog[i]), 32'(i % 11));

    // consumer stalls five cycles in HOLD
    do_reset();
    glog.delete();
    dat[2] = 18'h15A3C; req = 11'h004; out_ready = 1'b0;
    tick(); chk("st_sel", 32'(Sel), 32'(2));
    req = '0;
    tick(); chk("st_valid0", 32'(out_valid), 32'(1));
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("st_data", 32'(out_data), 32'h15A3C);
      chk("st_valid", 32'(out_valid), 32'(1));
      chk("st_sel_hold", 32'(Sel), 32'(2));
      chk("st_nogrant", 32'(grant), 32'(0));
    end
    out_ready = 1'b1;
    tick(); chk("st_grant", 32'(grant), 32'h004);

    // wrap past 10 from last=3
    glog.delete();
    req = 11'h008;
    wait_grants(1, 10);
    req = 11'h009;
    wait_grants(2, 20);
    req = '0;
    tick();
    chk("wrap_n", 32'(glog.size()), 32'(3));
    if (glog.size() >= 3) begin
      chk("wrap_first", 32'(glog[1]), 32'(0));
      chk("wrap_second", 32'(glog[2]), 32'(3));
    end

    // committed selection: req dropped in SELECT
    do_reset();
    glog.delete();
    dat[5] = 18'h3C0F1; req = 11'h020;
    tick(); chk("cm_sel", 32'(Sel), 32'(5));
    req = '0;
    tick(); chk("cm_data", 32'(out_data), 32'h3C0F1);
    tick(); chk("cm_grant", 32'(grant), 32'h020);

    // async reset in HOLD
    glog.delete();
    req = 11'h080; out_ready = 1'b0;
    tick(); tick();
    chk("ar_pre_valid", 32'(out_valid), 32'(1));
    req = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_sel", 32'(Sel), 32'hF);
    chk("ar_valid", 32'(out_valid), 32'(0));
    chk("ar_data", 32'(out_data), 32'(0));
    chk("ar_busy", 32'(busy), 32'(0));
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("ar_nogrant", 32'(glog.size()), 32'(0));
    req = 11'h401;
    wait_grants(1, 10);
    req = '0;
    if (glog.size() >= 1) chk("ar_first", 32'(glog[0]), 32'(0));
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 11, meaning number of requesters mapped to mux inputs 0..NREQ-1 (fixed at 11 for this release).
REQ-002 The block SHALL have parameter IDLE_SEL, default 4'b1111, meaning the Sel code driven when no transfer is active (mux default branch, output 0).
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  11  req[i]=1: requester i has a word on mux data input i.
REQ-006 Sel  output  4  select code to the 16x1 mux; registered.
REQ-007 DatSal  input  18  mux output word.
REQ-008 out_data  output  18  captured word presented to the consumer; registered.
REQ-009 out_valid  output  1  out_data holds a valid word.
REQ-010 out_ready  input  1  consumer accepts out_data when out_valid=1 on the same edge.
REQ-011 grant  output  11  one-hot, one-cycle pulse marking completion of requester i's transfer.
REQ-012 busy  output  1  1 in any state other than IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, SELECT, HOLD.
REQ-014 IDLE: if any req bit is 1, the arbiter SHALL choose index i = first set bit searching upward from last+1, wrapping 10 -> 0, register Sel=i, store i as cur, and go to SELECT; otherwise Sel=IDLE_SEL and state stays IDLE.
REQ-015 SELECT: the arbiter SHALL register DatSal into out_data, set out_valid=1, and go to HOLD (exactly one cycle).
REQ-016 HOLD: while out_ready=0, out_data, out_valid and Sel SHALL hold unchanged.
REQ-017 HOLD with out_ready=1: out_valid SHALL clear, grant[cur] SHALL pulse for exactly one cycle, last SHALL become cur, Sel SHALL return to IDLE_SEL, state SHALL go to IDLE.
REQ-018 Latency: req rising before edge k with arbiter idle -> Sel valid after edge k, out_valid after edge k+1, grant after the first edge with out_ready=1 (earliest k+2); peak throughput one word per 3 cycles.
REQ-019 A selection SHALL be committed: dropping req[cur] after leaving IDLE SHALL NOT abort the transfer; requester data is required stable until its grant.
REQ-020 Round-robin SHALL be fair: a continuously asserted requester SHALL be granted within 11 transfers.
REQ-021 Sel SHALL never take a value in 11..14; the only non-data code is IDLE_SEL.
REQ-022 grant SHALL be all-zero except the single cycle defined in REQ-017; at most one bit set.
REQ-023 req bits asserted in the same cycle SHALL resolve purely by the rotation pointer (no fixed priority).
REQ-024 busy SHALL equal (state != IDLE), registered with the state.

Reset
REQ-025 rst_n=0 SHALL immediately, without waiting for clk, force state=IDLE, Sel=IDLE_SEL, out_data=0, out_valid=0, grant=0, busy=0, last=10 (so first search begins at 0).
REQ-026 Reset asserted mid-transfer SHALL discard the transfer with no grant pulse; after release the first grant SHALL follow REQ-014 from last=10.
REQ-027 Outputs SHALL leave reset values no earlier than the first rising clk edge after rst_n rises.

Verification
REQ-028 Reset then req=11'h001, Dat0=18'h2A5A5, out_ready=1 -> Sel=0 after edge 1, out_data=18'h2A5A5 with out_valid=1 after edge 2, grant=11'h001 for one cycle after edge 3, Sel=4'b1111.
REQ-029 req=11'h7FF held, out_ready=1 -> grant sequence 0,1,...,10,0 one grant per 3 cycles; Sel never 11..14.
REQ-030 Single transfer with out_ready=0 for 5 cycles in HOLD -> out_data, out_valid=1, Sel stable for all 5 cycles; grant only after out_ready rises.
REQ-031 last=3, req=11'h009 -> next grant is 0 (wrap past 10), then 3.
REQ-032 req[5] dropped in SELECT -> transfer still completes and grant[5] pulses; rst_n pulsed low in HOLD -> outputs at reset values asynchronously, no grant pulse, next grant from index 0.
